// File: rtl/mem_ctrl_pair.sv
// mem_ctrl_pair
// Streams a block of up to DEPTH operand words from an input valid/ready bus
// into an external single-port synchronous RAM, then reads them back as
// (opa, opb) pairs for the FPU over a valid/ready handshake.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1; the sender holds valid and data stable until that edge, and the
// receiver may change ready freely.
//
// Ports:
//   mc_clk, mc_reset_n             clock (rising edge), async active-low reset
//   mc_load_start, mc_length       start a load of mc_length words
//   mc_in_valid/ready, mc_data_in  input word stream
//   mc_load_done                   pulse with the write of the last word
//   mc_fetch_start                 start pair read-out
//   mc_address_mem, mc_we,
//   mem_data_in, mem_data_out      RAM interface (read data one cycle late)
//   mc_data_out_opa/opb,
//   mc_op_valid, mc_op_ready       operand pair stream to the FPU
//   mc_done                        pulse after the last pair is accepted
//   mc_error                       sticky illegal-length flag
//   mc_state_dbg                   current FSM state (debug)
//
// Build option: define MC_WRAP_EN to replay the pair stream continuously
// (mc_done pulses after every pass; a new load is accepted in PRESENT).
module mem_ctrl_pair #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              mc_clk,
  input  logic              mc_reset_n,
  input  logic              mc_load_start,
  input  logic [ADDR_W:0]   mc_length,
  input  logic              mc_in_valid,
  output logic              mc_in_ready,
  input  logic [DATA_W-1:0] mc_data_in,
  output logic              mc_load_done,
  input  logic              mc_fetch_start,
  output logic [ADDR_W-1:0] mc_address_mem,
  output logic              mc_we,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] mc_data_out_opa,
  output logic [DATA_W-1:0] mc_data_out_opb,
  output logic              mc_op_valid,
  input  logic              mc_op_ready,
  output logic              mc_done,
  output logic              mc_error,
  output logic [2:0]        mc_state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STORE   = 3'd1,
    S_LOADED  = 3'd2,
    S_RD_A    = 3'd3,
    S_RD_B    = 3'd4,
    S_CAP_B   = 3'd5,
    S_PRESENT = 3'd6
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] TWO_L   = (ADDR_W+1)'(2);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic                load_done_q, load_done_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                in_ready;
  logic                len_ok;
  logic                load_state;
  logic [ADDR_W:0]     wr_plus1;
  logic [ADDR_W:0]     rd_plus1;
  logic [ADDR_W:0]     rd_plus2;

  assign in_ready = (state_q == S_STORE) && (wr_ptr_q < len_q);
  assign len_ok   = (mc_length != '0) && (mc_length <= DEPTH_L);
  assign wr_plus1 = wr_ptr_q + ONE_L;
  assign rd_plus1 = rd_ptr_q + ONE_L;
  // Pointers are one bit wider than the address, so rd_ptr+2 cannot wrap.
  assign rd_plus2 = rd_ptr_q + TWO_L;

`ifdef MC_WRAP_EN
  assign load_state = (state_q == S_IDLE) || (state_q == S_LOADED) ||
                      (state_q == S_PRESENT);
`else
  assign load_state = (state_q == S_IDLE) || (state_q == S_LOADED);
`endif

  // The RAM address register is loaded on the edge that enters RD_A / RD_B,
  // so the address is on the bus during that state and the read data arrives
  // in the following state.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    load_done_d = 1'b0;
    done_d      = 1'b0;
    error_d     = error_q;

    if (load_state && mc_load_start) begin
      // A load request takes priority over fetch_start and handshakes.
      if (!len_ok) begin
        error_d = 1'b1;
      end else begin
        error_d  = 1'b0;
        len_d    = mc_length;
        wr_ptr_d = '0;
        state_d  = S_STORE;
      end
    end else begin
      case (state_q)
        S_STORE: begin
          if (in_ready && mc_in_valid) begin
            we_d     = 1'b1;
            addr_d   = wr_ptr_q[ADDR_W-1:0];
            wdata_d  = mc_data_in;
            wr_ptr_d = wr_plus1;
            if (wr_plus1 == len_q) begin
              load_done_d = 1'b1;
              state_d     = S_LOADED;
            end
          end
        end
        S_LOADED: begin
          if (mc_fetch_start) begin
            rd_ptr_d = '0;
            addr_d   = '0;
            state_d  = S_RD_A;
          end
        end
        S_RD_A: begin
          addr_d  = rd_plus1[ADDR_W-1:0];
          state_d = S_RD_B;
        end
        S_RD_B: begin
          opa_d   = mem_data_out;
          state_d = S_CAP_B;
        end
        S_CAP_B: begin
          // Odd-length tail: the last pair carries a zero B operand.
          opb_d   = (rd_plus1 == len_q) ? '0 : mem_data_out;
          state_d = S_PRESENT;
        end
        S_PRESENT: begin
          if (mc_op_ready) begin
            if (rd_plus2 >= len_q) begin
              done_d = 1'b1;
`ifdef MC_WRAP_EN
              rd_ptr_d = '0;
              addr_d   = '0;
              state_d  = S_RD_A;
`else
              rd_ptr_d = rd_plus2;
              state_d  = S_LOADED;
`endif
            end else begin
              rd_ptr_d = rd_plus2;
              addr_d   = rd_plus2[ADDR_W-1:0];
              state_d  = S_RD_A;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge mc_clk or negedge mc_reset_n) begin
    if (!mc_reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      load_done_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      load_done_q <= load_done_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mc_in_ready     = in_ready;
  assign mc_load_done    = load_done_q;
  assign mc_address_mem  = addr_q;
  assign mc_we           = we_q;
  assign mem_data_in     = wdata_q;
  assign mc_data_out_opa = opa_q;
  assign mc_data_out_opb = opb_q;
  assign mc_op_valid     = (state_q == S_PRESENT);
  assign mc_done         = done_q;
  assign mc_error        = error_q;
  assign mc_state_dbg    = state_q;

endmodule

// File: tb/tb_mem_ctrl_pair.sv
// Directed bench for mem_ctrl_pair with a behavioural synchronous RAM.
module tb_mem_ctrl_pair;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_STORE   = 3'd1;
  localparam logic [2:0] ST_LOADED  = 3'd2;
  localparam logic [2:0] ST_RD_A    = 3'd3;
  localparam logic [2:0] ST_PRESENT = 3'd6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   length = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] data_in = '0;
  logic              load_done;
  logic              fetch_start = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              op_valid;
  logic              op_ready = 1'b0;
  logic              done;
  logic              error;
  logic [2:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ram [DEPTH];

  mem_ctrl_pair #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .mc_clk          (clk),
    .mc_reset_n      (rst_n),
    .mc_load_start   (load_start),
    .mc_length       (length),
    .mc_in_valid     (in_valid),
    .mc_in_ready     (in_ready),
    .mc_data_in      (data_in),
    .mc_load_done    (load_done),
    .mc_fetch_start  (fetch_start),
    .mc_address_mem  (addr),
    .mc_we           (we),
    .mem_data_in     (wdata),
    .mem_data_out    (rdata),
    .mc_data_out_opa (opa),
    .mc_data_out_opb (opb),
    .mc_op_valid     (op_valid),
    .mc_op_ready     (op_ready),
    .mc_done         (done),
    .mc_error        (error),
    .mc_state_dbg    (state_dbg)
  );

  // Clock and synchronous single-port RAM with one-cycle read latency.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) ram[addr] <= wdata;
    rdata <= ram[addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, {31'd0, we}, 32'd0);
    check({tag, "_addr"}, {26'd0, addr}, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_opa"}, opa, 32'd0);
    check({tag, "_opb"}, opb, 32'd0);
    check({tag, "_valid"}, {31'd0, op_valid}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_ldone"}, {31'd0, load_done}, 32'd0);
    check({tag, "_err"}, {31'd0, error}, 32'd0);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_state"}, {29'd0, state_dbg}, {29'd0, ST_IDLE});
  endtask

  task automatic start_load(input logic [ADDR_W:0] len);
    load_start = 1'b1;
    length     = len;
    tick();
    load_start = 1'b0;
  endtask

  logic [DATA_W-1:0] words4 [4];

  initial begin
    words4[0] = 32'h11; words4[1] = 32'h22;
    words4[2] = 32'h33; words4[3] = 32'h44;

    // Reset state.
    #3;
    check_all_zero("por");
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of an 8-word store after 3 words.
    start_load(7'd8);
    check("st8_state", {29'd0, state_dbg}, {29'd0, ST_STORE});
    check("st8_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 32'hA0 + i;
      tick();
    end
    check("st8_we", {31'd0, we}, 32'd1);
    check("st8_addr", {26'd0, addr}, 32'd2);
    check("st8_wdata", wdata, 32'hA2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Load four words with valid toggling every other cycle.
    start_load(7'd4);
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      data_in  = words4[i/2];
      tick();
      if (i % 2 == 0) begin
        check("ld4_we", {31'd0, we}, 32'd1);
        check("ld4_addr", {26'd0, addr}, i/2);
        check("ld4_wdata", wdata, words4[i/2]);
        check("ld4_ldone", {31'd0, load_done}, (i == 6) ? 32'd1 : 32'd0);
      end else begin
        check("ld4_we_idle", {31'd0, we}, 32'd0);
        check("ld4_ldone_idle", {31'd0, load_done}, 32'd0);
      end
    end
    check("ld4_state", {29'd0, state_dbg}, {29'd0, ST_LOADED});
    check("ld4_ready_off", {31'd0, in_ready}, 32'd0);

    // Fetch four words as two pairs with the FPU always ready.
    op_ready    = 1'b1;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("f4_valid1", {31'd0, op_valid}, 32'd0);
    tick();
    check("f4_valid2", {31'd0, op_valid}, 32'd0);
    tick();
    check("f4_valid3", {31'd0, op_valid}, 32'd0);
    tick();
    check("f4_valid4", {31'd0, op_valid}, 32'd1);
    check("f4_opa0", opa, 32'h11);
    check("f4_opb0", opb, 32'h22);
    tick();
    check("f4_rda_state", {29'd0, state_dbg}, {29'd0, ST_RD_A});
    check("f4_rda_addr", {26'd0, addr}, 32'd2);
    check("f4_done_early", {31'd0, done}, 32'd0);
    tick();
    tick();
    tick();
    check("f4_valid_p1", {31'd0, op_valid}, 32'd1);
    check("f4_opa1", opa, 32'h33);
    check("f4_opb1", opb, 32'h44);
    tick();
    check("f4_done", {31'd0, done}, 32'd1);
    check("f4_state_end", {29'd0, state_dbg}, {29'd0, ST_LOADED});
    tick();
    check("f4_done_once", {31'd0, done}, 32'd0);

    // Odd length 3 with back-pressure on the first pair.
    op_ready = 1'b0;
    start_load(7'd3);
    in_valid = 1'b1;
    data_in = 32'hA; tick();
    data_in = 32'hB; tick();
    data_in = 32'hC; tick();
    check("l3_ldone", {31'd0, load_done}, 32'd1);
    in_valid = 1'b0;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("l3_hold_valid", {31'd0, op_valid}, 32'd1);
      check("l3_hold_opa", opa, 32'hA);
      check("l3_hold_opb", opb, 32'hB);
      if (i == 4) op_ready = 1'b1;
      tick();
    end
    check("l3_rda", {29'd0, state_dbg}, {29'd0, ST_RD_A});
    tick();
    tick();
    tick();
    check("l3_tail_valid", {31'd0, op_valid}, 32'd1);
    check("l3_tail_opa", opa, 32'hC);
    check("l3_tail_opb", opb, 32'h0);
    tick();
    check("l3_done", {31'd0, done}, 32'd1);
    check("l3_state_end", {29'd0, state_dbg}, {29'd0, ST_LOADED});
    op_ready = 1'b0;

    // Illegal lengths leave the state alone and set the sticky error.
    start_load(7'd0);
    check("e0_err", {31'd0, error}, 32'd1);
    check("e0_state", {29'd0, state_dbg}, {29'd0, ST_LOADED});
    check("e0_we", {31'd0, we}, 32'd0);
    tick();
    check("e0_sticky", {31'd0, error}, 32'd1);
    start_load(7'd65);
    check("e65_err", {31'd0, error}, 32'd1);
    check("e65_state", {29'd0, state_dbg}, {29'd0, ST_LOADED});
    check("e65_we", {31'd0, we}, 32'd0);
    start_load(7'd2);
    check("e_clear", {31'd0, error}, 32'd0);
    check("e_clear_state", {29'd0, state_dbg}, {29'd0, ST_STORE});

    // Two-word block (5, 6), then one fetch pass.
    in_valid = 1'b1;
    data_in = 32'h5; tick();
    data_in = 32'h6; tick();
    in_valid = 1'b0;
    op_ready = 1'b1;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    tick();
    tick();
    check("w_opa0", opa, 32'h5);
    check("w_opb0", opb, 32'h6);
    check("w_valid0", {31'd0, op_valid}, 32'd1);
    tick();
    check("w_done0", {31'd0, done}, 32'd1);
`ifdef MC_WRAP_EN
    check("w_replay_state", {29'd0, state_dbg}, {29'd0, ST_RD_A});
    tick();
    tick();
    tick();
    check("w_opa1", opa, 32'h5);
    check("w_opb1", opb, 32'h6);
    check("w_valid1", {31'd0, op_valid}, 32'd1);
    op_ready = 1'b0;
    check("w_present", {29'd0, state_dbg}, {29'd0, ST_PRESENT});
    start_load(7'd1);
    check("w_reload", {29'd0, state_dbg}, {29'd0, ST_STORE});
`else
    check("w_single_state", {29'd0, state_dbg}, {29'd0, ST_LOADED});
    tick();
    check("w_done_once", {31'd0, done}, 32'd0);
    check("w_no_valid", {31'd0, op_valid}, 32'd0);
`endif
    op_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_pair.md
Name: mem_ctrl_pair

Overview:
Parametrised successor to the FPU memory controller. Streams a block of up to DEPTH operand words from the input bus into a single-port synchronous RAM, then reads them back as (opa, opb) pairs for the FPU through a valid/ready handshake. It sits between the input interface and the FPU register stage; the RAM is instantiated at top level. It replaces the fixed 32-bit/64-entry condition-code control with explicit handshakes, length checking and odd-length handling.

Parameters:
DATA_W, 32, operand/RAM word width
ADDR_W, 6, RAM address width
DEPTH, 64, RAM entries (must be <= 2**ADDR_W)

Ports:
mc_clk  in  1  clock, rising edge
mc_reset_n  in  1  asynchronous active-low reset
mc_load_start  in  1  1-cycle pulse: begin a load of mc_length words
mc_length  in  ADDR_W+1  word count for the load, sampled on mc_load_start
mc_in_valid  in  1  input word valid
mc_in_ready  out  1  controller accepts an input word
mc_data_in  in  DATA_W  input word
mc_load_done  out  1  1-cycle pulse: last word written
mc_fetch_start  in  1  1-cycle pulse: begin pair read-out
mc_address_mem  out  ADDR_W  RAM address (registered)
mc_we  out  1  RAM write enable (registered)
mem_data_in  out  DATA_W  RAM write data (registered)
mem_data_out  in  DATA_W  RAM read data, valid one cycle after the address is presented
mc_data_out_opa  out  DATA_W  operand A
mc_data_out_opb  out  DATA_W  operand B
mc_op_valid  out  1  operand pair valid
mc_op_ready  in  1  FPU accepts the pair
mc_done  out  1  1-cycle pulse: last pair accepted
mc_error  out  1  sticky illegal-length flag

Behaviour:
- Reset (async, mc_reset_n=0): state IDLE; all outputs 0; internal pointers and length 0. Reset asserted mid-operation aborts immediately; no partial state survives.
- States: IDLE, STORE, LOADED, RD_A, RD_B, CAP_B, PRESENT.
- IDLE/LOADED + mc_load_start:
  - mc_length==0 or >DEPTH: set mc_error=1 and stay in the current state.
  - Otherwise: clear mc_error, latch the length, set wr_ptr=0, go to STORE.
  - mc_load_start is ignored in every other state.
- STORE:
  - mc_in_ready=1 while wr_ptr<length.
  - Each accept (valid&&ready): next cycle mc_we=1, mc_address_mem=wr_ptr, mem_data_in=mc_data_in; then wr_ptr++.
  - No accept: mc_we=0 next cycle.
  - On the accept of the final word: mc_in_ready drops the next cycle, mc_load_done pulses in the same cycle as the final write, then go to LOADED.
- LOADED + mc_fetch_start: rd_ptr=0, go to RD_A. If mc_load_start and mc_fetch_start arrive in the same cycle, the load wins.
- Pair read-out:
  - RD_A: mc_address_mem=rd_ptr, mc_we=0.
  - RD_B: mc_address_mem=rd_ptr+1; opa<=mem_data_out.
  - CAP_B: opb<=mem_data_out. If rd_ptr+1==length (odd tail), opb<=0 instead.
  - PRESENT: mc_op_valid=1. opa/opb are held stable until mc_op_ready=1; valid must not drop without a handshake.
  - Latency: mc_fetch_start to first mc_op_valid is 4 cycles. Minimum 4 cycles per pair.
- PRESENT handshake:
  - rd_ptr+=2.
  - If rd_ptr>=length: mc_done pulses the next cycle, go to LOADED (RAM contents are retained, so re-fetch is allowed).
  - Otherwise: go to RD_A.
- Pointer arithmetic is ADDR_W+1 bits, so there is no wrap at DEPTH=2**ADDR_W. The RAM address is the low ADDR_W bits.
- Outputs that are not driven in a state hold their last value, except mc_we, mc_op_valid, mc_done and mc_load_done, which are 0 outside their defined cycles.

Optional Feature:
MC_WRAP_EN:
- Defined: after the last pair, PRESENT returns to RD_A with rd_ptr=0 and pulses mc_done every pass. This gives continuous replay until mc_load_start (accepted in PRESENT only) or reset.
- Undefined: single pass, return to LOADED as above.

Test Plan:
- Reset mid-STORE after 3 of 8 words -> all outputs 0; state IDLE; mc_in_ready=0.
- Load length=4 with words 0x11,0x22,0x33,0x44 and mc_in_valid toggling every other cycle -> 4 writes at addresses 0..3 with matching data; mc_load_done pulses once, together with the write to address 3.
- Fetch after length=4, mc_op_ready=1 -> pairs (0x11,0x22), (0x33,0x44); first mc_op_valid 4 cycles after mc_fetch_start; mc_done 1 cycle after the 2nd handshake.
- Length=3 (0xA,0xB,0xC), mc_op_ready held 0 for 5 cycles on the first pair -> (0xA,0xB) held stable with valid high for 5 cycles, then (0xC,0x0); done.
- mc_length=0, then 65 (DEPTH=64) -> mc_error=1, state unchanged, no writes; next legal load clears mc_error.
- MC_WRAP_EN, length=2 (0x5,0x6) -> pair (0x5,0x6) repeats; mc_done pulses after every pass; a mc_load_start in PRESENT restarts STORE.
